speed_mover: RTL
================

SPEED_MOVER -- requirements
Module: speed_mover

Interface
REQ-001 Parameter BASE_PERIOD, default 100000, clk cycles per step at speed 0 (100 ms at 1 MHz).
REQ-002 Parameter POS_MAX, default 15, highest position value (>=1).
REQ-003 clk  input  1  system clock, 1 MHz; all logic rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 state  input  2  game state from upstream controller: 0 setup, 1 run, 2 pause, 3 invalid.
REQ-006 speed_enable  input  1  upstream run/pause qualifier, 1 in states 1 and 2.
REQ-007 speed  input  3  selected speed level, 0 slowest .. 7 fastest.
REQ-008 pos  output  4  current object position, 0..POS_MAX.
REQ-009 dir  output  1  travel direction, 1 = increasing, 0 = decreasing.
REQ-010 step  output  1  one-cycle pulse on every position change.
REQ-011 bounce  output  1  one-cycle pulse when dir reverses.
REQ-012 laps  output  8  count of bounces at position 0, saturating.
REQ-013 running  output  1  1 while internal mode is RUN.

Function
REQ-014 Internal mode SHALL be decoded every cycle: RUN if state==1 and speed_enable==1; PAUSE if state==2; IDLE otherwise (state 0, state 3, or state 1 with speed_enable 0).
REQ-015 In IDLE: pos<=0, dir<=1, divider<=0, laps<=0, step<=0, bounce<=0, speed_lat<=speed (tracked every cycle).
REQ-016 speed_lat SHALL be frozen in RUN and PAUSE; changes on speed outside IDLE SHALL have no effect.
REQ-017 Step period SHALL be BASE_PERIOD >> speed_lat, forced to 1 if the shift yields 0.
REQ-018 In RUN: divider increments each cycle; when divider == period-1, divider<=0 and a move occurs that cycle; otherwise no move.
REQ-019 Move with dir=1 and pos<POS_MAX: pos<=pos+1, step<=1.
REQ-020 Move with dir=1 and pos==POS_MAX: pos<=POS_MAX-1, dir<=0, step<=1, bounce<=1.
REQ-021 Move with dir=0 and pos>0: pos<=pos-1, step<=1.
REQ-022 Move with dir=0 and pos==0: pos<=1, dir<=1, step<=1, bounce<=1, laps<=laps+1 unless laps==255 (hold 255).
REQ-023 step and bounce SHALL be registered, high for exactly the cycle after the move decision, 0 otherwise.
REQ-024 In PAUSE: pos, dir, divider, laps, speed_lat held; step=bounce=0; return to RUN resumes divider from held value.
REQ-025 RUN->IDLE or PAUSE->IDLE mid-period SHALL apply REQ-015 on the next edge; no step pulse generated.
REQ-026 Divider width SHALL hold BASE_PERIOD-1 without overflow; pos arithmetic never leaves 0..POS_MAX.
REQ-027 running SHALL be a registered copy of (mode==RUN), one cycle latency.

Reset
REQ-028 rst_n low SHALL asynchronously force pos=0, dir=1, step=0, bounce=0, laps=0, running=0, divider=0, speed_lat=0.
REQ-029 Release of rst_n SHALL take effect on the next rising clk; mode then decoded per REQ-014.
REQ-030 Reset asserted mid-RUN SHALL clear all state immediately regardless of clk.

Verification (BASE_PERIOD=8, POS_MAX=3)
REQ-031 state=0, speed=0, then state=1/speed_enable=1 -> step every 8 cycles, pos 0,1,2,3,2,1,0,1; bounce with pos->2 and pos->1 moves; laps=1 after pos 0->1.
REQ-032 Latch speed=3 in IDLE then RUN -> period 1, step every cycle; speed changed to 0 during RUN -> period remains 1.
REQ-033 RUN 5 cycles into a period, state=2 for 20 cycles, back to 1 -> pos unchanged during pause, next step 3 cycles after resume.
REQ-034 Force laps to 255 via long RUN at speed 3 -> laps stays 255 after further bottom bounces.
REQ-035 rst_n pulsed low mid-period in RUN -> outputs zero/dir=1 asynchronously; after release in state 1 first step after 8 cycles.
REQ-036 state=3 with speed_enable=1 -> IDLE behaviour, pos=0, running=0, no step.

Source files
------------

// File: rtl/speed_mover_if.sv
// Bundle between the game controller and the speed mover: controls in, motion state out.
// The master drives state/speed and observes motion; the mover is the slave.
interface speed_mover_if;
  logic [1:0] state;
  logic       speed_enable;
  logic [2:0] speed;
  logic [3:0] pos;
  logic       dir;
  logic       step;
  logic       bounce;
  logic [7:0] laps;
  logic       running;

  modport master (
    output state, speed_enable, speed,
    input  pos, dir, step, bounce, laps, running
  );

  modport slave (
    input  state, speed_enable, speed,
    output pos, dir, step, bounce, laps, running
  );
endinterface

// File: rtl/speed_mover.sv
// Ping-pong position mover: steps pos between 0 and POS_MAX at a rate set by a
// speed level latched while idle, counting bottom bounces as laps.
module speed_mover #(
  parameter int unsigned BASE_PERIOD = 100000,
  parameter int unsigned POS_MAX     = 15
) (
  input logic          clk,
  input logic          rst_n,
  speed_mover_if.slave bus
);

  localparam int         DIV_W   = (BASE_PERIOD > 1) ? $clog2(BASE_PERIOD) : 1;
  localparam logic [3:0] POS_TOP = 4'(POS_MAX);

  localparam logic [1:0] M_IDLE  = 2'd0;
  localparam logic [1:0] M_RUN   = 2'd1;
  localparam logic [1:0] M_PAUSE = 2'd2;

  logic [1:0]       mode;
  logic [3:0]       pos_q,  pos_d;
  logic             dir_q,  dir_d;
  logic [DIV_W-1:0] div_q,  div_d;
  logic [7:0]       laps_q, laps_d;
  logic [2:0]       spd_q,  spd_d;
  logic             step_q, step_d;
  logic             bnc_q,  bnc_d;
  logic             run_q,  run_d;
  logic [31:0]      period;
  logic             move;

  // Mode is a pure decode of the upstream inputs; it is not stored.
  always_comb begin
    mode = M_IDLE;
    if (bus.state == 2'd1 && bus.speed_enable) mode = M_RUN;
    else if (bus.state == 2'd2)                mode = M_PAUSE;
  end

  // Fast speeds can shift the period to zero; clamp so we still step every cycle.
  always_comb begin
    period = BASE_PERIOD >> spd_q;
    if (period == 32'd0) period = 32'd1;
  end

  assign move = (mode == M_RUN) && (32'(div_q) == period - 32'd1);

  always_comb begin
    pos_d  = pos_q;
    dir_d  = dir_q;
    div_d  = div_q;
    laps_d = laps_q;
    spd_d  = spd_q;
    step_d = 1'b0;
    bnc_d  = 1'b0;
    run_d  = (mode == M_RUN);
    case (mode)
      M_IDLE: begin
        pos_d  = 4'd0;
        dir_d  = 1'b1;
        div_d  = '0;
        laps_d = 8'd0;
        spd_d  = bus.speed;
      end
      M_RUN: begin
        if (move) begin
          div_d  = '0;
          step_d = 1'b1;
          if (dir_q) begin
            if (pos_q == POS_TOP) begin
              pos_d = POS_TOP - 4'd1;
              dir_d = 1'b0;
              bnc_d = 1'b1;
            end else begin
              pos_d = pos_q + 4'd1;
            end
          end else begin
            if (pos_q == 4'd0) begin
              pos_d  = 4'd1;
              dir_d  = 1'b1;
              bnc_d  = 1'b1;
              laps_d = (laps_q == 8'hFF) ? laps_q : laps_q + 8'd1;
            end else begin
              pos_d = pos_q - 4'd1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: ; // pause holds everything; pulses already default low
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q  <= 4'd0;
      dir_q  <= 1'b1;
      div_q  <= '0;
      laps_q <= 8'd0;
      spd_q  <= 3'd0;
      step_q <= 1'b0;
      bnc_q  <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      div_q  <= div_d;
      laps_q <= laps_d;
      spd_q  <= spd_d;
      step_q <= step_d;
      bnc_q  <= bnc_d;
      run_q  <= run_d;
    end
  end

  assign bus.pos     = pos_q;
  assign bus.dir     = dir_q;
  assign bus.step    = step_q;
  assign bus.bounce  = bnc_q;
  assign bus.laps    = laps_q;
  assign bus.running = run_q;

endmodule
